// File: rtl/fir_stream_pipe_if.sv
// Stream, coefficient-write and flush signals of fir_stream_pipe.
// The master drives samples and coefficients; the slave is the filter.
interface fir_stream_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_data;
  logic                     coef_we;
  logic [$clog2(TAPS)-1:0]  coef_addr;
  logic [COEF_W-1:0]        coef_wdata;
  logic                     flush;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, flush,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, flush,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_stream_pipe.sv
// Streaming FIR: delay line plus runtime coefficients, a product stage and a sum stage,
// one sample per cycle with a single global enable for output backpressure.
module fir_stream_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  fir_stream_pipe_if.slave  bus
);

  localparam int unsigned PW = DATA_W + COEF_W;

  logic [COEF_W-1:0] coef_q [TAPS];
  logic [COEF_W-1:0] coef_d [TAPS];
  logic [DATA_W-1:0] tap_q  [TAPS];
  logic [DATA_W-1:0] tap_d  [TAPS];
  logic [PW-1:0]     p_q    [TAPS];
  logic [PW-1:0]     p_d    [TAPS];
  logic              p_valid_q, p_valid_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic [ACC_W-1:0]  sum;
  logic              en;
  logic              in_ready;
  logic              accept;

  always_comb begin
    en       = !out_valid_q || bus.out_ready;
    in_ready = en && !bus.flush && !rst;
    accept   = bus.in_valid && in_ready;

    coef_d = coef_q;
    if (bus.coef_we && (32'(bus.coef_addr) < TAPS)) begin
      coef_d[bus.coef_addr] = bus.coef_wdata;
    end

    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + ACC_W'(p_q[k]);
    end

    tap_d       = tap_q;
    p_d         = p_q;
    p_valid_d   = p_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (bus.flush) begin
      for (int k = 0; k < TAPS; k++) begin
        tap_d[k] = '0;
      end
      p_valid_d   = 1'b0;
      out_valid_d = 1'b0;
    end else if (en) begin
      if (accept) begin
        tap_d[0] = bus.in_data;
        for (int k = 1; k < TAPS; k++) begin
          tap_d[k] = tap_q[k-1];
        end
        // Products use the post-shift view and the coefficients before this edge's write.
        for (int k = 0; k < TAPS; k++) begin
          p_d[k] = PW'(coef_q[k]) * PW'(tap_d[k]);
        end
      end
      p_valid_d   = accept;
      out_valid_d = p_valid_q;
      if (p_valid_q) begin
        out_data_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= COEF_W'(k + 1);
        tap_q[k]  <= '0;
        p_q[k]    <= '0;
      end
      p_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      coef_q      <= coef_d;
      tap_q       <= tap_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fir_stream_pipe.sv
// Self-checking bench for fir_stream_pipe: directed scenarios plus random traffic,
// scored against a convolution model over the accepted-sample history.
module tb_fir_stream_pipe;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned ACC_W  = 35;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_stream_pipe_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)) bus ();

  fir_stream_pipe #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: y[n] = sum coef[k] * x[n-k] over the accepted history.
  logic [63:0]       m_coef [TAPS];
  logic [DATA_W-1:0] m_hist [TAPS];
  logic [63:0]       exp_q  [$];
  logic [63:0]       last_out;
  int                n_out;
  logic              last_acc;

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = 64'(k + 1);
      m_hist[k] = '0;
    end
    exp_q.delete();
  endtask

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.coef_we   = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // Inputs are set at the falling edge; evaluate handshakes, then advance one cycle.
  task automatic step();
    logic        exp_ready;
    logic [63:0] y;
    #1;
    last_acc = 1'b0;
    if (rst) begin
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      model_reset();
    end else begin
      exp_ready = (!bus.out_valid || bus.out_ready) && !bus.flush;
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      if (bus.out_valid && !bus.out_ready) check("stall_ready", 64'(bus.in_ready), 64'd0);
      last_acc = bus.in_valid && exp_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(bus.out_valid), 64'd0);
        end else begin
          y = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), y);
          last_out = 64'(bus.out_data);
          n_out++;
        end
      end
      if (bus.flush) begin
        exp_q.delete();
        for (int k = 0; k < TAPS; k++) m_hist[k] = '0;
      end else if (last_acc) begin
        for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = bus.in_data;
        y = '0;
        for (int k = 0; k < TAPS; k++) y = y + m_coef[k] * 64'(m_hist[k]);
        exp_q.push_back(y);
      end
      if (bus.coef_we && (32'(bus.coef_addr) < TAPS)) m_coef[bus.coef_addr] = 64'(bus.coef_wdata);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    set_idle();
    for (int i = 0; i < 10; i++) step();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int guard;
    rst            = 1'b1;
    bus.in_data    = '0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    n_out          = 0;
    last_out       = '0;
    set_idle();
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_data", 64'(bus.out_data), 64'd0);
    #1 check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Impulse with latency check: output visible two cycles after the accept.
    n_out = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) check("lat_n1_valid", 64'(bus.out_valid), 64'd0);
      if (i == 2) begin
        check("lat_n2_valid", 64'(bus.out_valid), 64'd1);
        check("lat_n2_data", 64'(bus.out_data), 64'd1);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 0) ? 16'd1 : 16'd0;
      step();
    end
    drain("impulse_drain");
    check("impulse_count", 64'(n_out), 64'd9);

    // Flush drops history; a simultaneous in_valid is not accepted.
    for (int i = 0; i < 4; i++) send(16'd3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd9;
    step();
    set_idle();
    send(16'd1);
    drain("flush_drain");
    check("flush_out", last_out, 64'd1);

    // Coefficient write in the same cycle as accepting sample 5.
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) begin
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'd0;
        bus.coef_wdata = 16'd10;
      end
      send(16'(i));
      bus.coef_we = 1'b0;
    end
    drain("coef_drain");
    check("coef_upd_last", last_out, 64'd192);

    // Full scale with reset and then maximum coefficients.
    do_reset();
    for (int i = 0; i < 8; i++) send(16'hFFFF);
    drain("fs_drain");
    check("full_scale_36", last_out, 64'h23FFDC);
    for (int k = 0; k < TAPS; k++) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = 3'(k);
      bus.coef_wdata = 16'hFFFF;
      step();
    end
    bus.coef_we = 1'b0;
    for (int i = 0; i < 8; i++) send(16'hFFFF);
    drain("fs_max_drain");
    check("full_scale_max", last_out, 64'h7FFF00008);

    // Backpressure: stream 1..20 with random out_ready.
    do_reset();
    n_out = 0;
    sent  = 0;
    guard = 0;
    while (sent < 20 && guard < 500) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'(sent + 1);
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_acc) sent++;
      guard++;
    end
    check("bp_sent", 64'(sent), 64'd20);
    drain("bp_drain");
    check("bp_count", 64'(n_out), 64'd20);

    // Reset mid-stream with outputs in flight; coefficients return to k+1.
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'd3;
    bus.coef_wdata = 16'($urandom_range(100, 60000));
    step();
    bus.coef_we = 1'b0;
    send(16'd7);
    send(16'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    n_out = 0;
    for (int i = 0; i < 6; i++) step();
    check("rst_mid_silent", 64'(n_out), 64'd0);
    for (int i = 0; i < 8; i++) send((i == 0) ? 16'd1 : 16'd0);
    drain("rst_mid_drain");
    check("rst_mid_coef4", last_out, 64'd8);

    // Random traffic with coefficient writes and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_data    = 16'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.coef_we    = ($urandom_range(0, 15) == 0);
      bus.coef_addr  = 3'($urandom);
      bus.coef_wdata = 16'($urandom);
      bus.flush      = ($urandom_range(0, 31) == 0);
      step();
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_stream_pipe.md
# fir_stream_pipe

Streaming, pipelined, parametrised FIR filter; successor to the fixed 8-tap, 16-bit combinational FIR. It holds its own sample delay line and runtime-writable coefficients, and accepts one sample per cycle through a valid/ready handshake. It produces one full-precision output per accepted sample, with output backpressure. It sits between a sample source and any downstream consumer in the synthetic datapath set.

## Interface
- DATA_W, 16, input sample width (unsigned)
- COEF_W, 16, coefficient width (unsigned)
- TAPS, 8, number of taps, ≥2
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), output width; guarantees no overflow
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_W  input sample x[n]
- out_valid  out  1  output sample present
- out_ready  in  1  consumer accepts output this cycle
- out_data  out  ACC_W  y[n] = Σ coef[k]·x[n−k], k=0..TAPS−1
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index k
- coef_wdata  in  COEF_W  coefficient value
- flush  in  1  clear delay line and pipeline

## Operation
- Delay line tap[0..TAPS−1]; tap[0] is the newest sample. On accept (in_valid && in_ready): tap[0]←in_data, tap[k]←tap[k−1].
- Stage 1 (product regs): on accept, p[k] ← coef[k] × (k==0 ? in_data : tap[k−1]), computed with the post-shift view; p_valid←1.
- Stage 2 (output reg): out_data ← Σ p[k], full width, unsigned, zero-extended; out_valid ← p_valid.
- Global enable en = !out_valid || out_ready. in_ready = en && !flush. When en=0 all stages hold, including the delay line and p_valid.
- When en=1 and no accept occurs, p_valid←0, and the bubble propagates to out_valid.
- Coefficients: reset values coef[k]=k+1, which match the legacy block. The write takes effect at the clock edge: a sample accepted in the same cycle as coef_we uses the old value, and later samples use the new one. A coef_addr ≥ TAPS is ignored. Writes are allowed while stalled.
- flush (1 cycle): tap[*]←0, p_valid←0, out_valid←0; coefficients are retained. flush overrides a simultaneous in_valid (no accept) and drops any pending output.
- rst: tap[*]←0, p[*]←0, p_valid←0, out_valid←0, out_data←0, coef[k]←k+1. rst mid-stream discards all in-flight samples; rst has priority over flush and coef_we.
- The filter starts from zero history: the first TAPS−1 outputs after reset or flush are partial sums.

## Timing
- Reset values: in_ready=0 while rst=1, and 1 in the first cycle after reset; out_valid=0, out_data=0.
- Latency: a sample accepted in cycle n yields out_valid=1 in cycle n+2 with no stall.
- Throughput: 1 sample/cycle sustained while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, then in_ready=0 in the same cycle (combinational). out_data stays stable until consumed, and no sample is lost or duplicated.
- in_ready depends combinationally on out_ready, out_valid and flush only; it does not depend on in_valid.

## Test plan
- Impulse: reset coefs, send 1 then 8 zeros (one per cycle) → outputs 1,2,3,4,5,6,7,8,0; first output appears 2 cycles after the accept.
- Full scale: 8 samples of 0xFFFF → 8th output 0xFFFF×36 = 0x23FFDC; with all coefs written to 0xFFFF → 0xFFFF×0xFFFF×8 = 0x7FFF00008, no truncation in 35 bits.
- Backpressure: stream 1..20 with out_ready toggling in a random pattern → output sequence matches the golden model exactly; in_ready=0 in every cycle where out_valid && !out_ready.
- Coefficient update: write coef[0]=10 in the same cycle as accepting sample 5 → sample 5 output uses 1, sample 6 onward uses 10.
- Flush: after 4 samples of 3, assert flush, then send 1 → output 1 (no history); coefs unchanged.
- Reset mid-stream: reset with 2 outputs in flight → out_valid=0 the next cycle, nothing emitted afterwards, coefs back to k+1.
